// File: rtl/qtt_proc_initiator.sv
// ---------------------------------------------------------------------------
// qtt_proc_initiator
// Processor-side initiator for the time-tagger command/response port.
// Commands from the sequencer are queued in a small FIFO and issued one at a
// time as a one-cycle qtag_en_o strobe. Commands flagged cmd_rsp_i wait for
// qtag_vld_i (or a programmable timeout) and return a one-cycle rsp_vld_o.
//
// Parameters
//   CMD_FIFO_AW : command FIFO address width, depth = 2**CMD_FIFO_AW
//   TOUT_DW     : width of the timeout timer and cfg_tout_i
//
// Ports
//   c_clk_i, c_rst_ni          : core clock, async active-low reset
//   cmd_vld_i/op_i/dt_i/rsp_i  : command push (rsp_i = expects a response)
//   cmd_rdy_o                  : FIFO not full
//   cfg_tout_i                 : response timeout in cycles, 0 = forever
//   qtag_en_o/op_o/dt1_o       : command strobe + held command fields
//   qtag_rdy_i                 : tagger can accept a command
//   qtag_vld_i/dt1_i/dt2_i/flag_i : tagger response
//   rsp_vld_o                  : one-cycle response pulse
//   rsp_dt1_o/dt2_o/flag_o/tout_o : held response fields
//   busy_o, cmd_qty_o, tout_cnt_o : status
//
// Optional build macro QTT_INIT_FLUSH_EN adds flush_i: empties the FIFO,
// aborts any pending response and returns to IDLE.
// ---------------------------------------------------------------------------
module qtt_proc_initiator #(
    parameter int CMD_FIFO_AW = 3,
    parameter int TOUT_DW     = 16
) (
    input  logic                   c_clk_i,
    input  logic                   c_rst_ni,
`ifdef QTT_INIT_FLUSH_EN
    input  logic                   flush_i,
`endif
    input  logic                   cmd_vld_i,
    input  logic [4:0]             cmd_op_i,
    input  logic [31:0]            cmd_dt_i,
    input  logic                   cmd_rsp_i,
    output logic                   cmd_rdy_o,
    input  logic [TOUT_DW-1:0]     cfg_tout_i,
    output logic                   qtag_en_o,
    output logic [4:0]             qtag_op_o,
    output logic [31:0]            qtag_dt1_o,
    input  logic                   qtag_rdy_i,
    input  logic                   qtag_vld_i,
    input  logic [31:0]            qtag_dt1_i,
    input  logic [31:0]            qtag_dt2_i,
    input  logic                   qtag_flag_i,
    output logic                   rsp_vld_o,
    output logic [31:0]            rsp_dt1_o,
    output logic [31:0]            rsp_dt2_o,
    output logic                   rsp_flag_o,
    output logic                   rsp_tout_o,
    output logic                   busy_o,
    output logic [CMD_FIFO_AW:0]   cmd_qty_o,
    output logic [7:0]             tout_cnt_o
);

    localparam int DEPTH = 1 << CMD_FIFO_AW;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

    state_e                 state_q, state_d;
    logic [37:0]            mem_q [DEPTH];      // {rsp, op, dt}
    logic [CMD_FIFO_AW:0]   wr_ptr_q, rd_ptr_q, qty;
    logic                   full, empty, flush, push, pop, rsp_hit, tout_hit;
    logic                   rsp_pend_q;
    logic [TOUT_DW-1:0]     timer_q;
    logic                   en_q, rsp_vld_q, rsp_flag_q, rsp_tout_q;
    logic [4:0]             op_q;
    logic [31:0]            dt_q, rsp_dt1_q, rsp_dt2_q;
    logic [7:0]             tout_cnt_q;

`ifdef QTT_INIT_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Extra pointer bit distinguishes full from empty.
    assign qty   = wr_ptr_q - rd_ptr_q;
    assign full  = qty[CMD_FIFO_AW];
    assign empty = (qty == '0);
    assign push  = cmd_vld_i & ~full & ~flush;

    // ---- FSM: state register ----
    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pop) state_d = ST_ISSUE;
            ST_ISSUE: state_d = rsp_pend_q ? ST_WAIT : ST_IDLE;
            ST_WAIT:  if (rsp_hit || tout_hit) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // ---- FSM: outputs / control strobes ----
    always_comb begin
        pop      = 1'b0;
        rsp_hit  = 1'b0;
        tout_hit = 1'b0;
        case (state_q)
            ST_IDLE: pop = ~empty & qtag_rdy_i & ~flush;
            ST_WAIT: begin
                rsp_hit  = qtag_vld_i & ~flush;
                // A response arriving on the timeout cycle takes priority.
                tout_hit = ~qtag_vld_i & ~flush & (cfg_tout_i != '0) &
                           (timer_q == cfg_tout_i - TOUT_DW'(1));
            end
            default: ;
        endcase
    end

    // FIFO storage (no reset needed; validity is tracked by the pointers).
    always_ff @(posedge c_clk_i) begin
        if (push) mem_q[wr_ptr_q[CMD_FIFO_AW-1:0]] <= {cmd_rsp_i, cmd_op_i, cmd_dt_i};
    end

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rsp_pend_q <= 1'b0;
            timer_q    <= '0;
            en_q       <= 1'b0;
            op_q       <= '0;
            dt_q       <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_dt1_q  <= '0;
            rsp_dt2_q  <= '0;
            rsp_flag_q <= 1'b0;
            rsp_tout_q <= 1'b0;
            tout_cnt_q <= '0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            en_q <= pop;
            if (pop) begin
                {rsp_pend_q, op_q, dt_q} <= mem_q[rd_ptr_q[CMD_FIFO_AW-1:0]];
            end

            // Timer saturates so cfg_tout_i = 0 (wait forever) never wraps.
            if (state_q == ST_ISSUE)
                timer_q <= '0;
            else if (state_q == ST_WAIT && !tout_hit && timer_q != '1)
                timer_q <= timer_q + 1'b1;

            rsp_vld_q <= rsp_hit | tout_hit;
            if (rsp_hit) begin
                rsp_dt1_q  <= qtag_dt1_i;
                rsp_dt2_q  <= qtag_dt2_i;
                rsp_flag_q <= qtag_flag_i;
                rsp_tout_q <= 1'b0;
            end else if (tout_hit) begin
                rsp_dt1_q  <= '0;
                rsp_dt2_q  <= '0;
                rsp_flag_q <= 1'b0;
                rsp_tout_q <= 1'b1;
                if (tout_cnt_q != 8'hFF) tout_cnt_q <= tout_cnt_q + 8'd1;
            end
        end
    end

    assign cmd_rdy_o  = ~full;
    assign qtag_en_o  = en_q;
    assign qtag_op_o  = op_q;
    assign qtag_dt1_o = dt_q;
    assign rsp_vld_o  = rsp_vld_q;
    assign rsp_dt1_o  = rsp_dt1_q;
    assign rsp_dt2_o  = rsp_dt2_q;
    assign rsp_flag_o = rsp_flag_q;
    assign rsp_tout_o = rsp_tout_q;
    assign busy_o     = (state_q != ST_IDLE) | ~empty;
    assign cmd_qty_o  = qty;
    assign tout_cnt_o = tout_cnt_q;

endmodule
